// File: rtl/can_pkg.sv
// Shared CAN constants and helpers used by the transmit stuffer and receive destuffer.
// Contents: stuff run length, bus level encodings, run counter type and saturating increment,
//           and the per-strobe transmit action encoding.
package can_pkg;

  localparam int   CAN_STUFF_LEN = 5;
  localparam logic CAN_DOMINANT  = 1'b0;
  localparam logic CAN_RECESSIVE = 1'b1;

  typedef logic [2:0] run_cnt_t;

  // What the stuffer does at a transmit point.
  typedef enum logic [1:0] {
    TX_HOLD  = 2'd0,
    TX_DATA  = 2'd1,
    TX_STUFF = 2'd2,
    TX_URUN  = 2'd3
  } tx_act_e;

  // Increment a run count, saturating at lim.
  function automatic run_cnt_t run_inc(input run_cnt_t c, input int unsigned lim);
    return (c >= run_cnt_t'(lim)) ? c : c + 3'd1;
  endfunction

endpackage

// File: rtl/can_stuff_if.sv
// Link between a bit-stream user (stuffer/destuffer) and the shared run counter.
// master: user side, reports what happened on the bus this strobe; slave: run counter,
//         returns the stuff-pending flag and the last bus bit.
interface can_stuff_if;

  logic data_go;   // a frame bit went onto the bus this cycle
  logic stuff_go;  // a stuff bit went onto the bus this cycle
  logic urun_go;   // an underrun (recessive filler) went onto the bus this cycle
  logic bit_in;    // frame bit value when data_go
  logic stuff_en;  // stuffed region of the frame
  logic pend;      // a stuff bit is owed at the next transmit point
  logic last_bit;  // last bit placed on the bus (data or stuff)

  modport master (output data_go, stuff_go, urun_go, bit_in, stuff_en,
                  input  pend, last_bit);
  modport slave  (input  data_go, stuff_go, urun_go, bit_in, stuff_en,
                  output pend, last_bit);

endinterface

// File: rtl/can_run_counter.sv
// Run-length tracker for CAN bit stuffing: counts identical consecutive bus bits and raises
// stuff-pending once STUFF_LEN is reached inside the stuffed region.
// Ports: clk, rst (sync, active-high), lnk (slave side of can_stuff_if).
module can_run_counter
  import can_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN
) (
  input  logic        clk,
  input  logic        rst,
  can_stuff_if.slave  lnk
);

  run_cnt_t cnt_q, cnt_d;
  logic     last_q, last_d;
  logic     pend_q, pend_d;
  run_cnt_t cnt_nxt;

  assign lnk.pend     = pend_q;
  assign lnk.last_bit = last_q;

  always_comb begin
    cnt_d   = cnt_q;
    last_d  = last_q;
    pend_d  = pend_q;
    cnt_nxt = (lnk.bit_in == last_q) ? run_inc(cnt_q, STUFF_LEN) : 3'd1;

    if (lnk.stuff_go) begin
      // The stuff bit starts a new run of its own polarity.
      cnt_d  = 3'd1;
      last_d = ~last_q;
      pend_d = 1'b0;
    end else if (lnk.data_go) begin
      last_d = lnk.bit_in;
      if (lnk.stuff_en) begin
        cnt_d  = cnt_nxt;
        pend_d = (cnt_nxt == run_cnt_t'(STUFF_LEN));
      end else begin
        cnt_d  = 3'd0;
      end
    end else if (lnk.urun_go) begin
      cnt_d = 3'd0;
    end else if (!lnk.stuff_en && !pend_q) begin
      // Outside the stuffed region the run is meaningless; a stuff bit already owed
      // (after the last CRC bit) keeps the state until it is sent.
      cnt_d = 3'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= 3'd0;
      last_q <= CAN_RECESSIVE;
      pend_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      last_q <= last_d;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/can_stuff.sv
// CAN transmit bit stuffer: forwards upstream frame bits at each transmit point and inserts
// a complement bit after STUFF_LEN identical bits; underruns send recessive.
// Ports: i_Clk, i_Rst (sync, active-high); upstream i_Tx_Point/i_Stuff_En/i_Data_Valid/
//        i_Data_Bit/o_Data_Ready; bus o_Tx_Bit/o_Stuff_Active/o_Underrun; readback
//        i_Sample/i_Rx_Bit/o_Bit_Error. Macro CAN_STUFF_BITERR_EN enables bit-error checking.
module can_stuff
  import can_pkg::*;
#(
  parameter int STUFF_LEN = CAN_STUFF_LEN
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Tx_Point,
  input  logic i_Stuff_En,
  input  logic i_Data_Valid,
  input  logic i_Data_Bit,
  output logic o_Data_Ready,
  output logic o_Tx_Bit,
  output logic o_Stuff_Active,
  output logic o_Underrun,
  input  logic i_Sample,
  input  logic i_Rx_Bit,
  output logic o_Bit_Error
);

  can_stuff_if lnk ();

  can_run_counter #(.STUFF_LEN(STUFF_LEN)) u_run_counter (
    .clk (i_Clk),
    .rst (i_Rst),
    .lnk (lnk.slave)
  );

  tx_act_e act;
  logic    tx_bit_q, tx_bit_d;
  logic    stuff_act_q, stuff_act_d;
  logic    underrun_q, underrun_d;
  logic    bit_err_q, bit_err_d;

  // Upstream may only hand over a bit when no stuff bit is owed.
  assign o_Data_Ready = i_Tx_Point & ~lnk.pend;

  always_comb begin
    act = TX_HOLD;
    if (i_Tx_Point) begin
      if (lnk.pend)          act = TX_STUFF;
      else if (i_Data_Valid) act = TX_DATA;
      else                   act = TX_URUN;
    end
  end

  assign lnk.data_go  = (act == TX_DATA);
  assign lnk.stuff_go = (act == TX_STUFF);
  assign lnk.urun_go  = (act == TX_URUN);
  assign lnk.bit_in   = i_Data_Bit;
  assign lnk.stuff_en = i_Stuff_En;

  always_comb begin
    tx_bit_d    = tx_bit_q;
    stuff_act_d = stuff_act_q;
    underrun_d  = 1'b0;
    unique case (act)
      TX_STUFF: begin
        tx_bit_d    = ~lnk.last_bit;
        stuff_act_d = 1'b1;
      end
      TX_DATA: begin
        tx_bit_d    = i_Data_Bit;
        stuff_act_d = 1'b0;
      end
      TX_URUN: begin
        tx_bit_d    = CAN_RECESSIVE;
        stuff_act_d = 1'b0;
        underrun_d  = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef CAN_STUFF_BITERR_EN
  // Reading dominant while sending recessive outside the stuffed region is lost
  // arbitration or an ACK, not an error.
  always_comb begin
    bit_err_d = 1'b0;
    if (i_Sample && (i_Rx_Bit != tx_bit_q))
      bit_err_d = ~((tx_bit_q == CAN_RECESSIVE) && (i_Rx_Bit == CAN_DOMINANT) && !i_Stuff_En);
  end
`else
  logic unused_readback;
  assign unused_readback = i_Sample ^ i_Rx_Bit;
  always_comb bit_err_d = 1'b0;
`endif

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      tx_bit_q    <= CAN_RECESSIVE;
      stuff_act_q <= 1'b0;
      underrun_q  <= 1'b0;
      bit_err_q   <= 1'b0;
    end else begin
      tx_bit_q    <= tx_bit_d;
      stuff_act_q <= stuff_act_d;
      underrun_q  <= underrun_d;
      bit_err_q   <= bit_err_d;
    end
  end

  assign o_Tx_Bit       = tx_bit_q;
  assign o_Stuff_Active = stuff_act_q;
  assign o_Underrun     = underrun_q;
  assign o_Bit_Error    = bit_err_q;

endmodule

// File: tb/tb_can_stuff.sv
module tb_can_stuff;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_point = 1'b0;
  logic stuff_en = 1'b0;
  logic data_vld = 1'b0;
  logic data_bit = 1'b1;
  logic data_rdy;
  logic tx_bit;
  logic stuff_act;
  logic underrun;
  logic sample = 1'b0;
  logic rx_bit = 1'b1;
  logic bit_err;

  always #5 clk = ~clk;

  can_stuff dut (
    .i_Clk          (clk),
    .i_Rst          (rst),
    .i_Tx_Point     (tx_point),
    .i_Stuff_En     (stuff_en),
    .i_Data_Valid   (data_vld),
    .i_Data_Bit     (data_bit),
    .o_Data_Ready   (data_rdy),
    .o_Tx_Bit       (tx_bit),
    .o_Stuff_Active (stuff_act),
    .o_Underrun     (underrun),
    .i_Sample       (sample),
    .i_Rx_Bit       (rx_bit),
    .o_Bit_Error    (bit_err)
  );

`ifdef CAN_STUFF_BITERR_EN
  localparam logic EXP_BE = 1'b1;
`else
  localparam logic EXP_BE = 1'b0;
`endif

  typedef struct {
    logic  tx;
    logic  st;
    logic  ur;
    string nm;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: after every transmit point the DUT presents a new bus bit; between points
  // the bus bit must hold and no underrun may be flagged.
  logic mon_strobe, mon_rst;
  logic hold_tx = 1'b1;
  logic hold_st = 1'b0;
  exp_t e;

  always @(posedge clk) begin
    mon_strobe = tx_point;
    mon_rst    = rst;
    #1;
    if (mon_rst) begin
      hold_tx = 1'b1;
      hold_st = 1'b0;
    end else if (mon_strobe) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_strobe", 1, 0);
      end else begin
        e = sb.pop_front();
        chk({e.nm, "_tx"}, tx_bit, e.tx);
        chk({e.nm, "_stuff"}, stuff_act, e.st);
        chk({e.nm, "_urun"}, underrun, e.ur);
        hold_tx = e.tx;
        hold_st = e.st;
      end
    end else begin
      chk("hold_tx", tx_bit, hold_tx);
      chk("hold_stuff", stuff_act, hold_st);
      chk("hold_urun", underrun, 0);
    end
  end

  // One transmit point: present upstream inputs, check ready, queue the expected bus bit.
  task automatic strobe(input logic vld, input logic b, input logic sten,
                        input logic rdy, input logic tx, input logic st, input logic ur,
                        input string nm);
    @(negedge clk);
    data_vld = vld;
    data_bit = b;
    stuff_en = sten;
    tx_point = 1'b1;
    #1 chk({nm, "_rdy"}, data_rdy, rdy);
    sb.push_back('{tx, st, ur, nm});
    @(negedge clk);
    tx_point = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tx_point = 1'b0;
    data_vld = 1'b0;
    stuff_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic data_run(input logic b, input int n, input logic sten, input string nm);
    for (int i = 0; i < n; i++) strobe(1'b1, b, sten, 1'b1, b, 1'b0, 1'b0, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, tests %0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_tx", tx_bit, 1);
    chk("rst_stuff", stuff_act, 0);
    chk("rst_urun", underrun, 0);
    chk("rst_berr", bit_err, 0);
    chk("rst_rdy_idle", data_rdy, 0);
    rst = 1'b0;

    // 0,0,0,0,0,1 -> 0,0,0,0,0,1(stuff),1
    data_run(1'b0, 5, 1'b1, "s1_d0");
    strobe(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "s1_stuff");
    strobe(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "s1_d1");

    // 00000 1s 1111 0s 0
    do_reset();
    data_run(1'b0, 5, 1'b1, "s2_d0");
    strobe(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, "s2_stuff1");
    data_run(1'b1, 4, 1'b1, "s2_d1");
    strobe(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "s2_stuff0");
    strobe(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "s2_d0b");

    // Stuff after the last stuffed bit, then unstuffed ones
    do_reset();
    data_run(1'b1, 5, 1'b1, "s3_d1");
    strobe(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "s3_stuff0");
    data_run(1'b1, 5, 1'b0, "s3_nostuff");
    strobe(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "s3_after");

    // Underrun clears the run: 000, gap, 0000, then a data bit (no stuff)
    do_reset();
    data_run(1'b0, 3, 1'b1, "s4_d0");
    strobe(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "s4_urun");
    data_run(1'b0, 4, 1'b1, "s4_d0b");
    strobe(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, "s4_after");

    // Reset while a stuff bit is pending, with a simultaneous transmit point
    do_reset();
    data_run(1'b0, 5, 1'b1, "s5_d0");
    @(negedge clk);
    rst = 1'b1;
    tx_point = 1'b1;
    data_vld = 1'b1;
    data_bit = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tx_point = 1'b0;
    #1;
    chk("s5_rst_tx", tx_bit, 1);
    chk("s5_rst_stuff", stuff_act, 0);
    strobe(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "s5_first");

    // Bit error readback: bus bit is now 0
    @(negedge clk);
    sample = 1'b1;
    rx_bit = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    #1 chk("be_0v1_pulse", bit_err, EXP_BE);
    @(negedge clk);
    #1 chk("be_0v1_clear", bit_err, 0);
    // Send recessive outside the stuffed region, read dominant: not an error
    strobe(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "be_tx1");
    @(negedge clk);
    sample = 1'b1;
    rx_bit = 1'b0;
    stuff_en = 1'b0;
    @(negedge clk);
    sample = 1'b0;
    #1 chk("be_arb_loss", bit_err, 0);
    // Same readback inside the stuffed region is an error
    @(negedge clk);
    sample = 1'b1;
    stuff_en = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    #1 chk("be_1v0_stuffed", bit_err, EXP_BE);
    @(negedge clk);
    #1 chk("be_1v0_clear", bit_err, 0);

    repeat (3) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
